serial_adder: RTL and testbench



---
 rtl/serial_adder.sv | 143 ++++++++++++++
 tb/tb_serial_adder.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder: one full-adder cell, a registered carry and
// shift registers for the operands and the partial sum; one bit per clock.

module half_adder (
  input  logic a_i,
  input  logic b_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i;
  assign c_o = a_i & b_i;
endmodule

module or_gate (
  input  logic a_i,
  input  logic b_i,
  output logic y_o
);
  assign y_o = a_i | b_i;
endmodule

module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  logic s0, c0, c1;

  half_adder u_ha0 (.a_i(a_i), .b_i(b_i), .s_o(s0),  .c_o(c0));
  half_adder u_ha1 (.a_i(s0),  .b_i(c_i), .s_o(s_o), .c_o(c1));
  or_gate    u_or  (.a_i(c0),  .b_i(c1),  .y_o(c_o));
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             busy,
  output logic             done
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] part_q, part_d, sum_q, sum_d;
  logic [WIDTH-1:0] part_shift;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             c_q, c_d, cout_q, cout_d;
  logic             s_bit, co_bit, last_bit, accept;

  full_adder u_fa (.a_i(a_q[0]), .b_i(b_q[0]), .c_i(c_q), .s_o(s_bit), .c_o(co_bit));

  // Sum bits enter at the MSB so after WIDTH shifts bit 0 sits at the LSB.
  generate
    if (WIDTH == 1) begin : g_w1
      assign part_shift = s_bit;
    end else begin : g_wn
      assign part_shift = {s_bit, part_q[WIDTH-1:1]};
    end
  endgenerate

  assign last_bit = (cnt_q == CW'(WIDTH - 1));
  assign accept   = start && (state_q != RUN);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    part_d  = part_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    cout_d  = cout_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: state_d = IDLE;
      RUN: begin
        busy   = 1'b1;
        part_d = part_shift;
        a_d    = a_q >> 1;
        b_d    = b_q >> 1;
        c_d    = co_bit;
        cnt_d  = cnt_q + CW'(1);
        if (last_bit) begin
          sum_d   = part_shift;
          cout_d  = co_bit;
          state_d = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // DONE accepts a new start the same as IDLE, giving back-to-back runs.
    if (accept) begin
      a_d     = A;
      b_d     = B;
      c_d     = Cin;
      cnt_d   = '0;
      part_d  = '0;
      state_d = RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      part_q  <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      part_q  <= part_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      cout_q  <= cout_d;
    end
  end

  assign Sum  = sum_q;
  assign Cout = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: WIDTH=8 instance with directed and random
// additions, plus a WIDTH=1 instance for the single-bit corner.

module tb_serial_adder;
  localparam int W = 8;

  logic         clk = 1'b0, rst_n = 1'b0;
  logic         start = 1'b0, Cin = 1'b0;
  logic [W-1:0] A = '0, B = '0, Sum;
  logic         Cout, busy, done;

  logic start1 = 1'b0, Cin1 = 1'b0;
  logic [0:0] A1 = '0, B1 = '0, Sum1;
  logic Cout1, busy1, done1;

  int errors = 0, checks = 0;
  logic [W:0] exp_q[$];
  logic [1:0] exp1_q[$];
  logic [W:0] hold_exp = '0;
  logic [W:0] e_res;
  int run_len = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(W)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B), .Cin(Cin),
    .Sum(Sum), .Cout(Cout), .busy(busy), .done(done)
  );

  serial_adder #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .A(A1), .B(B1), .Cin(Cin1),
    .Sum(Sum1), .Cout(Cout1), .busy(busy1), .done(done1)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Monitor: results are popped only when done pulses; otherwise the
  // outputs must still show the last completed result.
  always @(negedge clk) if (rst_n) begin
    if (done) begin
      chk("busy_len", 64'(run_len), 64'(W));
      run_len = 0;
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending result");
      end else begin
        e_res = exp_q.pop_front();
        chk("result", {Cout, Sum}, e_res);
        hold_exp = e_res;
      end
    end else begin
      chk("hold", {Cout, Sum}, hold_exp);
      if (busy) run_len++;
      else run_len = 0;
    end
  end

  always @(negedge rst_n) begin
    hold_exp = '0;
    run_len  = 0;
  end

  always @(negedge clk) if (rst_n && done1) begin
    if (exp1_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL w1_unexpected_done: got done=1 expected none");
    end else begin
      chk("w1_result", {Cout1, Sum1}, exp1_q.pop_front());
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    logic [W:0] e;
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 40) begin @(negedge clk); n++; end
    chk("issue_wait", busy, 0);
    A = a; B = b; Cin = c; start = 1'b1;
    e = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    exp_q.push_back(e);
    @(posedge clk); #1 start = 1'b0;
    chk("accept_busy", busy, 1);
  endtask

  initial begin
    int n;
    #3;
    chk("rst_sum",  {Cout, Sum}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_w1",   {Cout1, Sum1, busy1, done1}, 0);
    @(negedge clk); rst_n = 1'b1;

    issue(8'h5A, 8'h3C, 1'b0);
    issue(8'hFF, 8'h01, 1'b0);
    issue(8'hFF, 8'hFF, 1'b1);

    // start held high through RUN with changing operands: no restart
    issue(8'h10, 8'h20, 1'b0);
    start = 1'b1; A = 8'h77; B = 8'h11;
    repeat (7) @(posedge clk);
    #1 start = 1'b0;

    // back-to-back pair
    issue(8'h21, 8'h42, 1'b1);
    issue(8'h01, 8'h02, 1'b0);

    // reset in the 4th RUN cycle
    issue(8'hAA, 8'h55, 1'b0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("midrst_sum",  {Cout, Sum}, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("idle_after_rst", busy, 0);
    issue(8'hAA, 8'h55, 1'b0);

    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 12)) @(negedge clk);
      issue(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
    end

    for (int k = 0; k < 8; k++) begin
      logic [2:0] v;
      logic [1:0] e1;
      v = 3'(k);
      @(negedge clk);
      A1 = v[0]; B1 = v[1]; Cin1 = v[2]; start1 = 1'b1;
      e1 = {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
      exp1_q.push_back(e1);
      @(posedge clk); #1 start1 = 1'b0;
      chk("w1_busy", busy1, 1);
      chk("w1_early_done", done1, 0);
      @(posedge clk); #1;
      chk("w1_done_lat", done1, 1);
      @(posedge clk); #1;
      chk("w1_done_pulse", done1, 0);
    end

    n = 0;
    while ((exp_q.size() > 0 || exp1_q.size() > 0) && n < 60) begin
      @(negedge clk); n++;
    end
    chk("drain", 64'(exp_q.size() + exp1_q.size()), 0);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
